// File: rtl/fade_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fade_pkg
// Description : Shared types and constants for the VGA fade slot core.
// Revision    : 1.0 - initial release
// ============================================================================
package fade_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        HOLD     = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_TGT    = 2'd1;
    localparam logic [1:0] REG_PERIOD = 2'd2;
    localparam logic [1:0] REG_HOLD   = 2'd3;

    localparam logic [4:0] ALPHA_MAX = 5'd16;

    localparam int CTRL_FADE_OUT_BIT = 0;
    localparam int CTRL_FADE_IN_BIT  = 1;
    localparam int CTRL_BYPASS_BIT   = 2;

endpackage
`default_nettype wire

// File: rtl/vga_fade_blend.sv
`default_nettype none
// ============================================================================
// Module      : vga_fade_blend
// Description : Combinational single-channel blend of si toward tgt by alpha/16.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fade_blend
    import fade_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [CW-1:0] i_si,
    input  logic [CW-1:0] i_tgt,
    input  logic [4:0]    i_alpha,
    output logic [CW-1:0] o_so
);

    localparam int WW = CW + 5;

    logic [WW-1:0] w_mix;

    // Weights sum to 16, so the shifted result never exceeds the channel range.
    assign w_mix = WW'(i_si) * WW'(ALPHA_MAX - i_alpha) + WW'(i_tgt) * WW'(i_alpha);
    assign o_so  = CW'(w_mix >> 4);

endmodule
`default_nettype wire

// File: rtl/chu_vga_fade_core.sv
`default_nettype none
// ============================================================================
// Module      : chu_vga_fade_core
// Description : Video-chain slot core fading the pixel stream toward a target
//               colour with a frame-paced alpha ramp. Optional macro
//               FADE_AUTO_RETURN_EN adds the timed return from HOLD.
// Revision    : 1.0 - initial release
// ============================================================================
module chu_vga_fade_core
    import fade_pkg::*;
#(
    parameter int            CD        = 12,
    parameter logic [CD-1:0] KEY_COLOR = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_start,
    input  logic          cs,
    input  logic          write,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    input  logic [CD-1:0] si_rgb,
    output logic [CD-1:0] so_rgb
);

    localparam int CW = CD / 3;

    fade_state_t   r_state, w_state_nx;
    logic [4:0]    r_alpha, w_alpha_nx;
    logic [7:0]    r_fcnt,  w_fcnt_nx;
    logic          r_pend_out, r_pend_in, r_bypass;
    logic [CD-1:0] r_tgt;
    logic [7:0]    r_period;
    logic [7:0]    w_per_m1;
    logic          w_step;
    logic          w_hold_done;
    logic [CD-1:0] w_blend;
    logic          w_wr, w_wr_ctrl, w_wr_tgt, w_wr_per;
    logic          w_unused;

    assign w_wr      = cs & write;
    assign w_wr_ctrl = w_wr && (addr[1:0] == REG_CTRL);
    assign w_wr_tgt  = w_wr && (addr[1:0] == REG_TGT);
    assign w_wr_per  = w_wr && (addr[1:0] == REG_PERIOD);
    assign w_unused  = ^{addr[13:2], wr_data};

    // A ctrl write in the same cycle as frame_start survives to the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_out <= 1'b0;
            r_pend_in  <= 1'b0;
            r_bypass   <= 1'b0;
            r_tgt      <= KEY_COLOR;
            r_period   <= 8'd1;
        end else begin
            if (frame_start) begin
                r_pend_out <= 1'b0;
                r_pend_in  <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_pend_out <= wr_data[CTRL_FADE_OUT_BIT];
                r_pend_in  <= wr_data[CTRL_FADE_IN_BIT] & ~wr_data[CTRL_FADE_OUT_BIT];
                r_bypass   <= wr_data[CTRL_BYPASS_BIT];
            end
            if (w_wr_tgt) r_tgt    <= wr_data[CD-1:0];
            if (w_wr_per) r_period <= wr_data[7:0];
        end
    end

`ifdef FADE_AUTO_RETURN_EN
    logic [7:0] r_hold;
    logic       w_wr_hold;

    assign w_wr_hold = w_wr && (addr[1:0] == REG_HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_hold <= 8'd0;
        else if (w_wr_hold) r_hold <= wr_data[7:0];
    end

    assign w_hold_done = (r_fcnt == r_hold);
`else
    assign w_hold_done = 1'b0;
`endif

    assign w_per_m1 = (r_period == 8'd0) ? 8'd0 : r_period - 8'd1;
    assign w_step   = (r_fcnt == w_per_m1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_alpha <= 5'd0;
            r_fcnt  <= 8'd0;
        end else begin
            r_state <= w_state_nx;
            r_alpha <= w_alpha_nx;
            r_fcnt  <= w_fcnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_alpha_nx = r_alpha;
        w_fcnt_nx  = r_fcnt;
        if (frame_start) begin
            case (r_state)
                IDLE: begin
                    if (r_pend_out) begin
                        w_state_nx = FADE_OUT;
                        w_fcnt_nx  = 8'd0;
                    end
                end
                FADE_OUT: begin
                    if (r_pend_in) begin
                        w_state_nx = FADE_IN;
                        w_fcnt_nx  = 8'd0;
                    end else if (r_alpha == ALPHA_MAX) begin
                        w_state_nx = HOLD;
                        w_fcnt_nx  = 8'd0;
                    end else if (w_step) begin
                        w_fcnt_nx  = 8'd0;
                        w_alpha_nx = r_alpha + 5'd1;
                        if (r_alpha == ALPHA_MAX - 5'd1) w_state_nx = HOLD;
                    end else begin
                        w_fcnt_nx  = r_fcnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (r_pend_in || w_hold_done) begin
                        w_state_nx = FADE_IN;
                        w_fcnt_nx  = 8'd0;
                    end
`ifdef FADE_AUTO_RETURN_EN
                    else begin
                        w_fcnt_nx  = r_fcnt + 8'd1;
                    end
`endif
                end
                FADE_IN: begin
                    if (r_pend_out) begin
                        w_state_nx = FADE_OUT;
                        w_fcnt_nx  = 8'd0;
                    end else if (r_alpha == 5'd0) begin
                        w_state_nx = IDLE;
                    end else if (w_step) begin
                        w_fcnt_nx  = 8'd0;
                        w_alpha_nx = r_alpha - 5'd1;
                        if (r_alpha == 5'd1) w_state_nx = IDLE;
                    end else begin
                        w_fcnt_nx  = r_fcnt + 8'd1;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < 3; g++) begin : g_ch
            vga_fade_blend #(.CW(CW)) u_blend (
                .i_si    (si_rgb[g*CW +: CW]),
                .i_tgt   (r_tgt[g*CW +: CW]),
                .i_alpha (r_alpha),
                .o_so    (w_blend[g*CW +: CW])
            );
        end
    endgenerate

    assign so_rgb = r_bypass ? si_rgb : w_blend;

endmodule
`default_nettype wire

// File: tb/tb_chu_vga_fade_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_chu_vga_fade_core
// Description : Self-checking bench for chu_vga_fade_core (honours
//               FADE_AUTO_RETURN_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chu_vga_fade_core;

    localparam int M_IDLE = 0, M_OUT = 1, M_HOLD = 2, M_IN = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start = 1'b0;
    logic        cs = 1'b0;
    logic        write = 1'b0;
    logic [13:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic [11:0] si_rgb = '0;
    logic [11:0] so_rgb;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_st, m_alpha, m_fc, m_per, m_hold;
    bit          m_po, m_pi, m_byp;
    logic [11:0] m_tgt;

    chu_vga_fade_core #(.CD(12), .KEY_COLOR(12'h000)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .cs          (cs),
        .write       (write),
        .addr        (addr),
        .wr_data     (wr_data),
        .si_rgb      (si_rgb),
        .so_rgb      (so_rgb)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_st = M_IDLE; m_alpha = 0; m_fc = 0; m_per = 1; m_hold = 0;
        m_po = 0; m_pi = 0; m_byp = 0; m_tgt = 12'h000;
    endtask

    // One paced alpha move in direction dir; ends the ramp at 16 or 0.
    task automatic m_ramp(input int dir);
        int pe;
        pe = (m_per == 0) ? 1 : m_per;
        if ((dir > 0 && m_alpha == 16) || (dir < 0 && m_alpha == 0)) begin
            m_st = (dir > 0) ? M_HOLD : M_IDLE;
            m_fc = 0;
            return;
        end
        if (m_fc == pe - 1) begin
            m_fc = 0;
            m_alpha += dir;
            if (m_alpha == 16) m_st = M_HOLD;
            if (m_alpha == 0)  m_st = M_IDLE;
        end else begin
            m_fc = (m_fc + 1) % 256;
        end
    endtask

    task automatic m_frame();
        case (m_st)
            M_IDLE: if (m_po) begin m_st = M_OUT; m_fc = 0; end
            M_OUT:  if (m_pi) begin m_st = M_IN; m_fc = 0; end else m_ramp(1);
            M_HOLD: begin
                if (m_pi) begin m_st = M_IN; m_fc = 0; end
`ifdef FADE_AUTO_RETURN_EN
                else if (m_fc == m_hold) begin m_st = M_IN; m_fc = 0; end
                else m_fc = (m_fc + 1) % 256;
`endif
            end
            default: if (m_po) begin m_st = M_OUT; m_fc = 0; end else m_ramp(-1);
        endcase
    endtask

    task automatic m_clock(input bit fs, input bit w, input logic [1:0] a, input logic [31:0] d);
        if (fs) begin
            m_frame();
            m_po = 0;
            m_pi = 0;
        end
        if (w) begin
            case (a)
                2'd0: begin m_po = d[0]; m_pi = d[1] && !d[0]; m_byp = d[2]; end
                2'd1: m_tgt = d[11:0];
                2'd2: m_per = int'(d[7:0]);
                default: m_hold = int'(d[7:0]);
            endcase
        end
    endtask

    function automatic logic [11:0] m_so(input logic [11:0] si);
        logic [11:0] r;
        int s, t;
        if (m_byp) return si;
        for (int c = 0; c < 3; c++) begin
            s = int'((si >> (4 * c)) & 12'hF);
            t = int'((m_tgt >> (4 * c)) & 12'hF);
            r[4*c +: 4] = 4'((s * (16 - m_alpha) + t * m_alpha) / 16);
        end
        return r;
    endfunction

    // Drive one cycle (entered just after a negedge), then check at the next negedge.
    task automatic cyc(input bit fs, input bit w, input logic [1:0] a, input logic [31:0] d);
        frame_start = fs;
        cs          = w;
        write       = w;
        addr        = {12'($urandom), a};
        wr_data     = d;
        @(posedge clk);
        m_clock(fs, w, a, d);
        @(negedge clk);
        chk("so_model", {20'h0, so_rgb}, {20'h0, m_so(si_rgb)});
        frame_start = 1'b0;
        cs          = 1'b0;
        write       = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, a, d);
    endtask

    task automatic frame();
        cyc(1'b1, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1 m_reset();
        chk("rst_so", {20'h0, so_rgb}, {20'h0, si_rgb});
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic start_fade(input logic [11:0] tgt, input logic [7:0] per);
        wr(2'd1, {20'h0, tgt});
        wr(2'd2, {24'h0, per});
        wr(2'd0, 32'h1);
    endtask

    initial begin
        m_reset();
        si_rgb = 12'h5A3;
        repeat (2) @(negedge clk);
        chk("rst_pass", {20'h0, so_rgb}, 32'h5A3);
        reset = 1'b1;

        // Reset target (KEY_COLOR 0) reached at full fade
        wr(2'd0, 32'h1);
        repeat (17) frame();
        chk("key_color", {20'h0, so_rgb}, 32'h000);
        do_reset();

        // Period 1 ramp toward white from black
        si_rgb = 12'h000;
        start_fade(12'hFFF, 8'd1);
        frame();
        chk("ramp_a0", {20'h0, so_rgb}, 32'h000);
        for (int k = 1; k <= 16; k++) begin
            frame();
            chk("ramp_k", {20'h0, so_rgb}, {20'h0, {3{4'(k - 1)}}});
        end
        chk("ramp_full", {20'h0, so_rgb}, 32'hFFF);
        do_reset();

        // Period 3, reverse at alpha 7
        si_rgb = 12'h000;
        start_fade(12'hFFF, 8'd3);
        for (int i = 0; i < 100 && m_alpha != 7; i++) frame();
        chk("p3_a7", {20'h0, so_rgb}, 32'h666);
        wr(2'd0, 32'h2);
        for (int i = 0; i < 100 && m_st != M_IDLE; i++) frame();
        chk("p3_back", {20'h0, so_rgb}, 32'h000);
        repeat (4) frame();
        do_reset();

        // Command written together with frame_start waits one frame
        si_rgb = 12'hFFF;
        wr(2'd1, 32'h000);
        cyc(1'b1, 1'b1, 2'd0, 32'h1);
        chk("same_cyc", {20'h0, so_rgb}, 32'hFFF);
        repeat (3) frame();
        do_reset();

        // Bypass during HOLD
        si_rgb = 12'h123;
        start_fade(12'h0F0, 8'd1);
        repeat (17) frame();
        chk("hold_tgt", {20'h0, so_rgb}, 32'h0F0);
        wr(2'd0, 32'h4);
        chk("byp_on", {20'h0, so_rgb}, 32'h123);
        wr(2'd0, 32'h0);
        chk("byp_off", {20'h0, so_rgb}, 32'h0F0);
        do_reset();

        // Asynchronous reset mid-fade at alpha 9
        si_rgb = 12'h345;
        start_fade(12'hFFF, 8'd1);
        for (int i = 0; i < 40 && m_alpha != 9; i++) frame();
        do_reset();
        chk("rst_mid", {20'h0, so_rgb}, 32'h345);
        frame();
        chk("post_rst", {20'h0, so_rgb}, 32'h345);

`ifdef FADE_AUTO_RETURN_EN
        do_reset();
        si_rgb = 12'h000;
        wr(2'd3, 32'h2);
        start_fade(12'hFFF, 8'd1);
        repeat (17) frame();
        for (int k = 0; k < 3; k++) begin
            frame();
            chk("auto_hold", {20'h0, so_rgb}, 32'hFFF);
        end
        frame();
        chk("auto_fi", {20'h0, so_rgb}, 32'hEEE);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit          fs, w;
            logic [1:0]  a;
            logic [31:0] d;
            fs = ($urandom % 4) == 0;
            w  = ($urandom % 6) == 0;
            a  = 2'($urandom % 4);
            case (a)
                2'd0:    d = ($urandom % 4) | ((($urandom % 5) == 0) ? 32'h4 : 32'h0);
                2'd1:    d = $urandom;
                default: d = $urandom % 4;
            endcase
            si_rgb = 12'($urandom);
            cyc(fs, w, a, d);
            if (($urandom % 1000) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
